// File: rtl/sw_led_ctrl_if.sv
// Board-side signal bundle for sw_led_ctrl: raw switches in, LED and status out.
interface sw_led_ctrl_if;
  logic       sw0;
  logic       sw1;
  logic       led0;
  logic [1:0] sw_db;
  logic       chg;
  logic [1:0] state;

  modport master (output sw0, sw1, input led0, sw_db, chg, state);
  modport slave  (input sw0, sw1, output led0, sw_db, chg, state);
endinterface

// File: rtl/sw_led_ctrl.sv
// Synchronises and debounces two switches, forms f = db0 ^ db1 and drives led0
// through a Moore FSM: IDLE (off), ON (solid for a hold period), BLINK.
module sw_led_ctrl #(
  parameter int DB_CYCLES  = 4,
  parameter int ON_CYCLES  = 16,
  parameter int BLINK_HALF = 8
) (
  input  logic         clk,
  input  logic         rst,
  sw_led_ctrl_if.slave bus
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(ON_CYCLES + 1);
  localparam int BCNT_W = $clog2(BLINK_HALF + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ON_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLINK = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  logic [1:0]        raw;
  logic [1:0]        s1_q, s1_d;
  logic [1:0]        s2_q, s2_d;
  logic [1:0]        db_q, db_d;
  logic [DB_W-1:0]   cnt_q [2];
  logic [DB_W-1:0]   cnt_d [2];
  logic              chg_q, chg_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic              f;
  logic              led0;

  assign raw = {bus.sw1, bus.sw0};

  // Two-flop synchroniser per switch.
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
  end

  // A new level is accepted only after it has been seen DB_CYCLES edges in a row.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i] = s2_q[i];
        else                     cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
    chg_d = (db_d != db_q);
  end

  assign f = db_q[0] ^ db_q[1];

  // f==0 is tested first so it wins over the hold timeout and the phase toggle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (f) begin
          state_d = ST_ON;
          hold_d  = '0;
        end
      end
      ST_ON: begin
        if (!f) begin
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_BLINK;
          phase_d = 1'b1;
          bcnt_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_BLINK: begin
        if (!f) begin
          state_d = ST_IDLE;
        end else if (bcnt_q == BCNT_LAST) begin
          phase_d = ~phase_q;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output: depends on registered state only.
  always_comb begin
    case (state_q)
      ST_ON:    led0 = 1'b1;
      ST_BLINK: led0 = phase_q;
      default:  led0 = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      chg_q    <= 1'b0;
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      chg_q    <= chg_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
    end
  end

  assign bus.led0  = led0;
  assign bus.sw_db = db_q;
  assign bus.chg   = chg_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed and randomized stimulus for sw_led_ctrl, checked every cycle against a
// timestamp-based behavioural model of debounce, chg and LED sequencing.
module tb_sw_led_ctrl;
  localparam int DB = 4;
  localparam int ON = 16;
  localparam int BH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sw_led_ctrl_if bus ();

  sw_led_ctrl #(.DB_CYCLES(DB), .ON_CYCLES(ON), .BLINK_HALF(BH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: synchroniser pipe, accepted levels, and timestamps.
  bit [1:0] m_s1, m_s2, m_db;
  bit       m_chg;
  int       diff_since [2];
  bit       m_active;
  int       m_on_start;
  int       m_edge = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_edge);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_chg = 1'b0;
    diff_since[0] = -1; diff_since[1] = -1;
    m_active = 1'b0;
  endtask

  // One clock: drive inputs at negedge, advance the model on the edge, compare #1 later.
  task automatic step(input bit r, input bit a, input bit b);
    bit [1:0] db_new;
    bit       f_pre;
    int       t;
    int       exp_state;
    bit       exp_led;
    @(negedge clk);
    rst     = r;
    bus.sw0 = a;
    bus.sw1 = b;
    @(posedge clk);
    m_edge++;
    if (!r) begin
      model_reset();
    end else begin
      f_pre  = m_db[0] ^ m_db[1];
      db_new = m_db;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_db[i]) begin
          diff_since[i] = -1;
        end else begin
          if (diff_since[i] < 0) diff_since[i] = m_edge;
          if (m_edge - diff_since[i] + 1 >= DB) begin
            db_new[i]     = m_s2[i];
            diff_since[i] = -1;
          end
        end
      end
      m_chg = (db_new != m_db);
      if (!f_pre) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        m_active   = 1'b1;
        m_on_start = m_edge;
      end
      m_db = db_new;
      m_s2 = m_s1;
      m_s1 = {b, a};
    end
    #1;
    exp_state = 0;
    exp_led   = 1'b0;
    if (m_active) begin
      t = m_edge - m_on_start;
      if (t < ON) begin
        exp_state = 1;
        exp_led   = 1'b1;
      end else begin
        exp_state = 2;
        exp_led   = (((t - ON) / BH) % 2) == 0;
      end
    end
    check("sw_db", 8'(bus.sw_db), 8'(m_db));
    check("chg",   8'(bus.chg),   8'(m_chg));
    check("state", 8'(bus.state), 8'(exp_state));
    check("led0",  8'(bus.led0),  8'(exp_led));
  endtask

  task automatic hold(input bit r, input bit a, input bit b, input int cycles);
    for (int k = 0; k < cycles; k++) step(r, a, b);
  endtask

  initial begin
    bus.sw0 = 1'b0;
    bus.sw1 = 1'b0;
    model_reset();

    // Reset with switches high, then release and let them debounce to 11.
    hold(0, 1, 1, 3);
    hold(1, 1, 1, 10);
    hold(1, 0, 0, 10);

    // Nominal ON then several blink half-periods.
    hold(1, 1, 0, 60);
    hold(1, 0, 0, 10);

    // Glitch shorter than the debounce window.
    hold(1, 0, 1, 3);
    hold(1, 0, 0, 12);
    hold(1, 1, 0, 2);
    hold(1, 0, 0, 12);

    // Simultaneous change: f unchanged, single chg pulse.
    hold(1, 1, 1, 12);
    hold(1, 0, 0, 12);

    // Abort from ON at hold count 10, then full restart of the hold period.
    hold(1, 1, 0, 16);
    hold(1, 1, 1, 10);
    hold(1, 1, 0, 33);

    // One-cycle reset during a phase=0 half of BLINK, sw0 still set.
    hold(0, 1, 0, 1);
    hold(1, 1, 0, 30);
    hold(1, 0, 0, 10);

    // Randomized segments: levels held for random lengths, occasional reset.
    for (int seg = 0; seg < 400; seg++) begin
      bit a, b, r;
      int len;
      a   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 39) != 0);
      len = r ? $urandom_range(1, 30) : $urandom_range(1, 2);
      hold(r, a, b, len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
